fetch_controller: RTL and testbench

Sequencer for the 16-entry, 8-bit instruction memory. Owns the program counter, drives the memory's 4-bit `prog_count` address, and captures the memory's combinational `ins_val` output into a one-deep instruction register. It delivers instructions to the decode stage over a valid/ready handshake and supports start, redirect (branch/jump), external stop, and self-halt on a halt opcode.

---
 rtl/fetch_controller_pkg.sv | 15 +
 rtl/fetch_controller.sv | 123 ++++++++++++
 tb/tb_fetch_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared constants and state type for the instruction fetch sequencer.
package fetch_controller_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int INDEX_SIZE = 4;
  localparam logic [WORD_SIZE-1:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller.sv
// Program-counter sequencer: addresses instruction memory, captures the read word
// into a one-deep instruction register and hands it to decode over valid/ready.
//
// state  | meaning
// IDLE   | not fetching, waiting for start
// FETCH  | capturing one instruction per free slot
// DRAIN  | halt opcode captured, waiting for decode to accept it
// HALTED | halt delivered, program ended
module fetch_controller #(
  parameter int WORD_SIZE  = fetch_controller_pkg::WORD_SIZE,
  parameter int INDEX_SIZE = fetch_controller_pkg::INDEX_SIZE,
  parameter logic [WORD_SIZE-1:0] HALT_OPCODE = fetch_controller_pkg::HALT_OPCODE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INDEX_SIZE-1:0] start_addr,
  input  logic                  stop,
  input  logic                  redirect_valid,
  input  logic [INDEX_SIZE-1:0] redirect_addr,
  input  logic [WORD_SIZE-1:0]  ins_val,
  output logic [INDEX_SIZE-1:0] prog_count,
  output logic [WORD_SIZE-1:0]  ir,
  output logic [INDEX_SIZE-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic                  busy,
  output logic                  halted
);

  import fetch_controller_pkg::*;

  fetch_state_t          state, state_next;
  logic [INDEX_SIZE-1:0] pc_next;
  logic [WORD_SIZE-1:0]  ir_next;
  logic [INDEX_SIZE-1:0] ir_pc_next;
  logic                  ir_valid_next;
  logic                  slot_free;

  assign slot_free = !ir_valid || ir_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prog_count <= '0;
      ir         <= '0;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
    end else begin
      state      <= state_next;
      prog_count <= pc_next;
      ir         <= ir_next;
      ir_pc      <= ir_pc_next;
      ir_valid   <= ir_valid_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = prog_count;
    ir_next       = ir;
    ir_pc_next    = ir_pc;
    ir_valid_next = ir_valid;

    case (state)
      IDLE: begin
        if (!stop && start) begin
          pc_next    = start_addr;
          state_next = FETCH;
        end
      end

      HALTED: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          pc_next    = start_addr;
          state_next = FETCH;
        end
      end

      FETCH: begin
        if (stop) begin
          ir_valid_next = 1'b0;
          state_next    = IDLE;
        end else if (redirect_valid) begin
          ir_valid_next = 1'b0;
          pc_next       = redirect_addr;
        end else if (slot_free) begin
          ir_next       = ins_val;
          ir_pc_next    = prog_count;
          ir_valid_next = 1'b1;
          // The halt word parks the PC on itself so a later start is explicit.
          if (ins_val == HALT_OPCODE) begin
            state_next = DRAIN;
          end else begin
            pc_next = prog_count + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (stop) begin
          ir_valid_next = 1'b0;
          state_next    = IDLE;
        end else if (redirect_valid) begin
          ir_valid_next = 1'b0;
          pc_next       = redirect_addr;
          state_next    = FETCH;
        end else if (ir_valid && ir_ready) begin
          ir_valid_next = 1'b0;
          state_next    = HALTED;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state == FETCH) || (state == DRAIN);
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed program scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic       stop = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [3:0] redirect_addr = '0;
  logic       ir_ready = 1'b0;
  logic [7:0] ins_val;
  logic [3:0] prog_count;
  logic [7:0] ir;
  logic [3:0] ir_pc;
  logic       ir_valid;
  logic       busy;
  logic       halted;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  int         m_pc;
  int         m_irpc;
  logic [7:0] m_ir;
  bit         m_valid, m_active, m_drain, m_done;

  always #5 clk = ~clk;

  assign ins_val = mem[prog_count];

  fetch_controller dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .ins_val(ins_val),
    .prog_count(prog_count), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .busy(busy), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_pc = 0; m_irpc = 0; m_ir = 8'h00;
    m_valid = 0; m_active = 0; m_drain = 0; m_done = 0;
  endtask

  task automatic model_edge();
    if (stop) begin
      if (m_active) begin
        m_active = 0; m_drain = 0; m_valid = 0;
      end
      m_done = 0;
    end else if (m_active && redirect_valid) begin
      m_valid = 0; m_drain = 0; m_pc = redirect_addr;
    end else if (!m_active) begin
      if (start) begin
        m_pc = start_addr; m_done = 0; m_active = 1;
      end
    end else if (m_drain) begin
      if (ir_ready) begin
        m_valid = 0; m_drain = 0; m_active = 0; m_done = 1;
      end
    end else if (!m_valid || ir_ready) begin
      m_ir = mem[m_pc]; m_irpc = m_pc; m_valid = 1;
      if (m_ir == 8'hFF) m_drain = 1;
      else m_pc = (m_pc + 1) % 16;
    end
  endtask

  task automatic compare_all();
    check("prog_count", prog_count, m_pc);
    check("ir", ir, m_ir);
    check("ir_pc", ir_pc, m_irpc);
    check("ir_valid", ir_valid, m_valid);
    check("busy", busy, m_active);
    check("halted", halted, m_done);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic expect_slot(input string tag, input int pc, input int word);
    check({tag, "_valid"}, ir_valid, 1);
    check({tag, "_pc"}, ir_pc, pc);
    check({tag, "_ir"}, ir, word);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, prog_count, 0);
    check({tag, "_ir"}, ir, 0);
    check({tag, "_ir_pc"}, ir_pc, 0);
    check({tag, "_valid"}, ir_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    mem[5] = 8'hFF;

    #12;
    check_reset_values("reset");
    rst = 1'b0;

    // straight-line program ending in halt
    start = 1'b1; start_addr = 4'd0; ir_ready = 1'b1;
    tick();
    check("t1_start_pc", prog_count, 0);
    check("t1_start_valid", ir_valid, 0);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_slot("t1_seq", i, (i == 5) ? 8'hFF : 8'h10 + i);
    end
    tick();
    check("t1_halted", halted, 1);
    check("t1_busy", busy, 0);

    // backpressure while ir holds 8'h12
    start = 1'b1; start_addr = 4'd0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    expect_slot("t2_before", 2, 8'h12);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_slot("t2_hold", 2, 8'h12);
      check("t2_hold_prog_count", prog_count, 3);
    end
    ir_ready = 1'b1;
    tick(); expect_slot("t2_resume", 3, 8'h13);
    tick(); expect_slot("t2_next", 4, 8'h14);
    tick(); expect_slot("t2_halt", 5, 8'hFF);
    tick(); check("t2_halted", halted, 1);
    stop = 1'b1;
    tick();
    check("t2_stop_halted", halted, 0);
    check("t2_stop_busy", busy, 0);
    stop = 1'b0;

    // wraparound without a halt opcode
    mem[5] = 8'h15;
    start = 1'b1; start_addr = 4'd14;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_slot("t3_wrap", (14 + k) % 16, 8'h10 + ((14 + k) % 16));
    end

    // redirect while ir_pc=3 is valid
    tick(); tick();
    expect_slot("t4_pre", 3, 8'h13);
    redirect_valid = 1'b1; redirect_addr = 4'd9;
    tick();
    check("t4_bubble_valid", ir_valid, 0);
    check("t4_bubble_pc", prog_count, 9);
    redirect_valid = 1'b0;
    tick();
    expect_slot("t4_target", 9, 8'h19);

    // stop beats redirect on the same edge
    stop = 1'b1; redirect_valid = 1'b1; redirect_addr = 4'd2;
    tick();
    check("t5_busy", busy, 0);
    check("t5_valid", ir_valid, 0);
    check("t5_pc_held", prog_count, 10);
    stop = 1'b0; redirect_valid = 1'b0;
    tick();
    check("t5_idle", busy, 0);

    // asynchronous reset mid-stream
    start = 1'b1; start_addr = 4'd0;
    tick();
    start = 1'b0;
    tick(); tick();
    expect_slot("t6_pre", 1, 8'h11);
    rst = 1'b1;
    #1;
    check_reset_values("t6_async");
    model_reset();
    rst = 1'b0;
    start = 1'b1; start_addr = 4'd0;
    tick();
    check("t6_restart_pc", prog_count, 0);
    start = 1'b0;
    tick();
    expect_slot("t6_first", 0, 8'h10);

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 256 == 0) begin
        for (int a = 0; a < 16; a++)
          mem[a] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      end
      start          = ($urandom_range(0, 7) == 0);
      start_addr     = 4'($urandom_range(0, 15));
      stop           = ($urandom_range(0, 31) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr  = 4'($urandom_range(0, 15));
      ir_ready       = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
